// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Serial receive front end for the UART path. It synchronises the raw rxd pin,
// recovers 8N1 frames using 16x oversampling, and hands each byte downstream
// on a valid/ready handshake. It sits directly upstream of uart_ctrl's byte
// input. Framing errors and overruns are reported as single-cycle pulses.
//
// Parameters
//   CLK_DIV    clk cycles per oversample tick (bit period = 16*CLK_DIV clks)
//   DATA_BITS  data bits per frame, LSB first, no parity, one stop bit
//
// Ports
//   clk        in   1          system clock
//   rst        in   1          synchronous, active-high reset
//   rxd        in   1          asynchronous serial line, idles high
//   rx_data    out  DATA_BITS  received byte, stable while rx_valid=1
//   rx_valid   out  1          byte available; held until rx_ready
//   rx_ready   in   1          consumer accepts rx_data this cycle
//   frame_err  out  1          1-clk pulse: stop bit sampled low
//   overrun    out  1          1-clk pulse: new byte dropped, buffer full
//   busy       out  1          1 while the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
   parameter int CLK_DIV   = 27,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic                 rxd_meta;
   logic                 rxd_s;
   logic [TICK_W-1:0]    tick_cnt;
   logic                 tick;
   logic [3:0]           samp_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;

   // FSM strobes decoded in the output process
   logic start_go;    // falling edge seen while idle
   logic start_ok;    // start bit confirmed low at its midpoint
   logic data_smp;    // mid-bit sample of a data bit
   logic stop_ok;     // stop bit sampled high: deliver the byte
   logic stop_bad;    // stop bit sampled low: framing error

   logic mid_tick;
   logic end_tick;

   assign tick     = (tick_cnt == TICK_LAST);
   assign mid_tick = tick && (samp_cnt == 4'd7);
   assign end_tick = tick && (samp_cnt == 4'd15);

   // ---- stage: input synchroniser (two flops, idle-high) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
      end
   end

   // ---- stage: oversample tick and sample counter ----
   // Both counters restart on the start edge so the start-bit midpoint lands
   // a fixed 8 ticks later; the sample counter restarts again once the start
   // bit is confirmed so every data/stop sample falls 16 ticks apart.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (start_go || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         samp_cnt <= 4'd0;
      end else if (start_go || start_ok) begin
         samp_cnt <= 4'd0;
      end else if (tick) begin
         samp_cnt <= samp_cnt + 4'd1;
      end
   end

   // ---- stage: FSM state register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- stage: FSM next-state logic ----
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (!rxd_s) state_nxt = START;
         end
         START: begin
            // A start bit that is high again at its midpoint was a glitch.
            if (mid_tick) state_nxt = rxd_s ? IDLE : DATA;
         end
         DATA: begin
            if (end_tick && (bit_cnt == BIT_LAST)) state_nxt = STOP;
         end
         STOP: begin
            // Returning to IDLE at mid stop bit lets a back-to-back start
            // bit be caught; a low stop bit parks in BRK until the line
            // recovers so a held-low line never restarts a frame.
            if (end_tick) state_nxt = rxd_s ? IDLE : BRK;
         end
         BRK: begin
            if (rxd_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- stage: FSM output decode ----
   always_comb begin
      start_go = 1'b0;
      start_ok = 1'b0;
      data_smp = 1'b0;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      busy     = 1'b1;
      unique case (state)
         IDLE: begin
            busy     = 1'b0;
            start_go = !rxd_s;
         end
         START: begin
            start_ok = mid_tick && !rxd_s;
         end
         DATA: begin
            data_smp = end_tick;
         end
         STOP: begin
            stop_ok  = end_tick && rxd_s;
            stop_bad = end_tick && !rxd_s;
         end
         BRK: begin
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ---- stage: data bit counter and shift register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
      end else if (start_ok) begin
         bit_cnt <= '0;
      end else if (data_smp) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   // LSB arrives first, so shifting right leaves it at bit 0 after the last bit.
   always_ff @(posedge clk) begin
      if (data_smp) begin
         shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
      end
   end

   // ---- stage: output buffer, handshake and status pulses ----
   // A delivery landing in the same cycle as a consumer transfer refills the
   // buffer, so rx_valid stays high with the new byte and no overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (stop_ok) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun  <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
//
// Directed bench for uart_rx_deframer with CLK_DIV=4 (bit period 64 clks).
// Inputs change on the falling clock edge; a background monitor samples just
// after each falling edge and tallies valid cycles, transfers, error pulses and
// busy cycles, which the scenario tasks compare with hand-derived values.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

   localparam int CLK_DIV   = 4;
   localparam int DATA_BITS = 8;
   localparam int BIT_CLKS  = 16 * CLK_DIV;

   logic                 clk;
   logic                 rst;
   logic                 rxd;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;
   logic                 busy;

   int n_tests;
   int n_fail;

   int                   n_valid_cyc;
   int                   n_accept;
   int                   n_ferr;
   int                   n_ovr;
   int                   n_busy;
   logic [DATA_BITS-1:0] last_acc;

   uart_rx_deframer #(
      .CLK_DIV   (CLK_DIV),
      .DATA_BITS (DATA_BITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: looks 1 time unit after each falling edge, when inputs set on
   // that edge are settled and outputs are mid-cycle stable.
   always @(negedge clk) begin
      #1;
      if (rx_valid === 1'b1) n_valid_cyc = n_valid_cyc + 1;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
         n_accept = n_accept + 1;
         last_acc = rx_data;
      end
      if (frame_err === 1'b1) n_ferr = n_ferr + 1;
      if (overrun === 1'b1) n_ovr = n_ovr + 1;
      if (busy === 1'b1) n_busy = n_busy + 1;
   end

   task automatic clear_counts();
      n_valid_cyc = 0;
      n_accept    = 0;
      n_ferr      = 0;
      n_ovr       = 0;
      n_busy      = 0;
      last_acc    = '0;
   endtask

   // Drive one 8N1 frame; must be called right at a falling edge.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      rxd = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      rxd      = 1'b0;
      rx_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         rxd = ~rxd;
      end
      n_tests++;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
      end
      n_tests++;
      if (rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rx_data: got %h expected 00", rx_data);
      end
      n_tests++;
      if (frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_frame_err: got %b expected 0", frame_err);
      end
      n_tests++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_overrun: got %b expected 0", overrun);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_basic_rx();
      clear_counts();
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1);
      repeat (10) @(negedge clk);
      n_tests++;
      if (n_valid_cyc != 1) begin
         n_fail++;
         $display("FAIL basic_valid_cycles: got %0d expected 1", n_valid_cyc);
      end
      n_tests++;
      if (n_accept != 1 || last_acc !== 8'hA5) begin
         n_fail++;
         $display("FAIL basic_data: got %0d transfers data %h expected 1 transfer data a5",
                  n_accept, last_acc);
      end
      n_tests++;
      if (n_ferr != 0 || n_ovr != 0) begin
         n_fail++;
         $display("FAIL basic_pulses: got frame_err %0d overrun %0d expected 0 0", n_ferr, n_ovr);
      end
      n_tests++;
      if (busy !== 1'b0 || rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_idle: got busy %b rx_valid %b expected 0 0", busy, rx_valid);
      end
   endtask

   // Low for 20 clks: start confirmed false at the 8th tick, 32 clks of busy.
   task automatic test_glitch();
      clear_counts();
      rxd = 1'b0;
      repeat (20) @(negedge clk);
      rxd = 1'b1;
      repeat (100) @(negedge clk);
      n_tests++;
      if (n_busy != 32) begin
         n_fail++;
         $display("FAIL glitch_busy_cycles: got %0d expected 32", n_busy);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_back_idle: got busy %b expected 0", busy);
      end
      n_tests++;
      if (n_valid_cyc != 0 || n_ferr != 0) begin
         n_fail++;
         $display("FAIL glitch_no_output: got valid %0d frame_err %0d expected 0 0",
                  n_valid_cyc, n_ferr);
      end
   endtask

   task automatic test_break();
      clear_counts();
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b0);
      repeat (200) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL break_busy_held: got %b expected 1", busy);
      end
      n_tests++;
      if (n_ferr != 1) begin
         n_fail++;
         $display("FAIL break_frame_err_pulse: got %0d cycles expected 1", n_ferr);
      end
      n_tests++;
      if (n_valid_cyc != 0 || n_ovr != 0) begin
         n_fail++;
         $display("FAIL break_no_byte: got valid %0d overrun %0d expected 0 0",
                  n_valid_cyc, n_ovr);
      end
      rxd = 1'b1;
      repeat (10) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL break_release: got busy %b expected 0", busy);
      end
      clear_counts();
      send_frame(8'h5A, 1'b1);
      repeat (10) @(negedge clk);
      n_tests++;
      if (n_accept != 1 || last_acc !== 8'h5A || n_ferr != 0) begin
         n_fail++;
         $display("FAIL break_recover: got %0d transfers data %h frame_err %0d expected 1 5a 0",
                  n_accept, last_acc, n_ferr);
      end
   endtask

   task automatic test_overrun();
      clear_counts();
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (5) @(negedge clk);
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL overrun_hold: got valid %b data %h expected 1 11", rx_valid, rx_data);
      end
      n_tests++;
      if (n_ovr != 1 || n_ferr != 0) begin
         n_fail++;
         $display("FAIL overrun_pulse: got overrun %0d frame_err %0d expected 1 0", n_ovr, n_ferr);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (n_accept != 1 || last_acc !== 8'h11) begin
         n_fail++;
         $display("FAIL overrun_accept: got %0d transfers data %h expected 1 11", n_accept, last_acc);
      end
      n_tests++;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_valid_drop: got %b expected 0", rx_valid);
      end
      rx_ready = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // Second delivery lands 611 clks after its start edge; rx_ready is high
   // only in the cycle before that edge, so 0x11 leaves as 0x22 arrives.
   task automatic test_back_to_back();
      clear_counts();
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (611 - 1) @(posedge clk);
            @(negedge clk);
            rx_ready = 1'b1;
            @(negedge clk);
            n_tests++;
            if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
               n_fail++;
               $display("FAIL b2b_refill: got valid %b data %h expected 1 22", rx_valid, rx_data);
            end
            n_tests++;
            if (overrun !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_no_overrun: got %b expected 0", overrun);
            end
            rx_ready = 1'b0;
         end
      join
      repeat (5) @(negedge clk);
      n_tests++;
      if (n_accept != 1 || last_acc !== 8'h11 || n_ovr != 0) begin
         n_fail++;
         $display("FAIL b2b_first_taken: got %0d transfers data %h overrun %0d expected 1 11 0",
                  n_accept, last_acc, n_ovr);
      end
      n_tests++;
      if (rx_valid !== 1'b1 || rx_data !== 8'h22) begin
         n_fail++;
         $display("FAIL b2b_second_held: got valid %b data %h expected 1 22", rx_valid, rx_data);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (n_accept != 2 || last_acc !== 8'h22 || rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: got %0d transfers data %h valid %b expected 2 22 0",
                  n_accept, last_acc, rx_valid);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      clear_counts();
      @(negedge clk);
      test_reset();
      test_basic_rx();
      test_glitch();
      test_break();
      test_overrun();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
